// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
//   Shares one external 8-bit combinational ALU between two requesters.
//   A request is granted in IDLE, its operands are registered onto the alu_*
//   bus, the result is captured one cycle later, and it is returned on a
//   single response channel tagged with the owning requester's ID.
//
// Parameters:
//   FIXED_PRIO  0 = round-robin on ties, 1 = requester 0 always wins ties
//
// Optional feature (compile-time macro ALU_ZERO_FLAG_EN):
//   adds output rsp_zero, set when the captured result is 8'h00.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid[1:0]             per-requester valid
//   req_ready[1:0]             per-requester accept strobe (one-hot or zero)
//   req_a, req_b [15:0]        operands {req1, req0}
//   req_op [5:0]               ALU selects {req1, req0}
//   rsp_valid/rsp_ready        response handshake
//   rsp_id, rsp_data, rsp_carry response payload
//   alu_a, alu_b, alu_sel      registered operands/select to the ALU
//   alu_out, alu_cout          combinational ALU result and carry of A+B
//   rsp_zero                   zero flag (only with ALU_ZERO_FLAG_EN)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; grants and latches operands
// EXEC  | ALU settles on registered inputs; result captured at edge
// RESP  | response held valid until rsp_ready

module alu_req_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [5:0]  req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [7:0]  rsp_data,
    output logic        rsp_carry,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_sel,
    input  logic [7:0]  alu_out,
    input  logic        alu_cout
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic        rsp_zero
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic       last_grant;
    logic       grant_id;

    always_comb begin
        grant_id = 1'b0;
        case (req_valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
            default: grant_id = 1'b0;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && req_valid != 2'b00) begin
            req_ready = grant_id ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;   // requester 0 wins the first tie
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= 8'h00;
            rsp_carry  <= 1'b0;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            alu_sel    <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid != 2'b00) begin
                        alu_a      <= grant_id ? req_a[15:8] : req_a[7:0];
                        alu_b      <= grant_id ? req_b[15:8] : req_b[7:0];
                        alu_sel    <= grant_id ? req_op[5:3] : req_op[2:0];
                        rsp_id     <= grant_id;
                        last_grant <= grant_id;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_out;
                    // the ALU always reports the carry of A+B; only add owns it
                    rsp_carry <= (alu_sel == 3'b000) ? alu_cout : 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_zero <= 1'b0;
        end else if (state == EXEC) begin
            rsp_zero <= (alu_out == 8'h00);
        end
    end
`endif

endmodule
